fpu_wb_queue: RTL

- Result queue directly downstream of the FPU output packer. It accepts packed, NaN-boxed FLEN-wide results with destination register and exception flags.
- Holds them in a small FIFO until the FP register-file write port grants.
- Accumulates fflags at commit and provides a pending-destination lookup for the scoreboard.

---
 rtl/fpu_wb_queue.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/fpu_wb_queue.sv
// Result FIFO between the FPU output packer and the FP register-file write port.
// Define FPU_NANBOX_CHECK_EN to enable the NaN-box check on enqueue (BoxErr tied to 0 otherwise).
module fpu_wb_queue #(
    parameter int unsigned FLEN    = 64,
    parameter int unsigned FMTBITS = 2,
    parameter int unsigned DEPTH   = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               InValid,
    output logic               InReady,
    input  logic [FLEN-1:0]    InResult,
    input  logic [FMTBITS-1:0] InFmt,
    input  logic [4:0]         InRd,
    input  logic [4:0]         InFlags,
    output logic               WbValid,
    input  logic               WbReady,
    output logic [FLEN-1:0]    WbResult,
    output logic [4:0]         WbRd,
    input  logic               Flush,
    output logic [4:0]         FFlags,
    input  logic               FFlagsWe,
    input  logic [4:0]         FFlagsWrData,
    input  logic [4:0]         RdQuery,
    output logic               RdHit,
    output logic               BoxErr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      count;
    logic [AW-1:0]      wr_idx, rd_idx;
    logic               full, empty, enq, deq;

    logic [FLEN-1:0]    res_q   [DEPTH];
    logic [FLEN-1:0]    res_d   [DEPTH];
    logic [FMTBITS-1:0] fmt_q   [DEPTH];
    logic [FMTBITS-1:0] fmt_d   [DEPTH];
    logic [4:0]         rd_q    [DEPTH];
    logic [4:0]         rd_d    [DEPTH];
    logic [4:0]         flags_q [DEPTH];
    logic [4:0]         flags_d [DEPTH];

    logic [4:0]         fflags_q, fflags_d;
    logic [4:0]         head_flags;
    logic [FLEN-1:0]    store_result;
    logic               unused_fmt;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];
    assign count  = wr_ptr_q - rd_ptr_q;
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // No bypass: a same-cycle dequeue does not open a slot when full.
    assign InReady = !full;
    assign WbValid = !empty;

    // Flush kills both handshakes so neither storage nor fflags see them.
    assign enq = InValid && InReady && !Flush;
    assign deq = WbValid && WbReady && !Flush;

    assign WbResult   = res_q[rd_idx];
    assign WbRd       = rd_q[rd_idx];
    assign head_flags = flags_q[rd_idx];
    assign FFlags     = fflags_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
    end

    always_comb begin
        fflags_d = (FFlagsWe ? FFlagsWrData : fflags_q) | (deq ? head_flags : 5'b0);
    end

    always_comb begin
        res_d   = res_q;
        fmt_d   = fmt_q;
        rd_d    = rd_q;
        flags_d = flags_q;
        if (enq) begin
            res_d[wr_idx]   = store_result;
            fmt_d[wr_idx]   = InFmt;
            rd_d[wr_idx]    = InRd;
            flags_d[wr_idx] = InFlags;
        end
    end

    // Entry i is live when its distance from the head is below the occupancy.
    always_comb begin
        RdHit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (({1'b0, AW'(i) - rd_idx} < count) && (rd_q[i] == RdQuery)) begin
                RdHit = 1'b1;
            end
        end
    end

    // Stored format is carried for completeness but never read back.
    always_comb begin
        unused_fmt = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            unused_fmt = unused_fmt ^ (^fmt_q[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fflags_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                res_q[i]   <= '0;
                fmt_q[i]   <= '0;
                rd_q[i]    <= '0;
                flags_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fflags_q <= fflags_d;
            res_q    <= res_d;
            fmt_q    <= fmt_d;
            rd_q     <= rd_d;
            flags_q  <= flags_d;
        end
    end

`ifdef FPU_NANBOX_CHECK_EN
    logic [FLEN-1:0] upper_mask;
    logic [FLEN-1:0] canon_nan;
    logic [127:0]    qnan;
    int unsigned     fmt_len;
    logic            malformed;
    logic            box_err_q, box_err_d;

    always_comb begin
        fmt_len = 128;
        qnan    = '0;
        case (InFmt)
            FMTBITS'(0): begin
                fmt_len = 32;
                qnan    = 128'h7FC0_0000;
            end
            FMTBITS'(1): begin
                fmt_len = 64;
                qnan    = 128'h7FF8_0000_0000_0000;
            end
            FMTBITS'(2): begin
                fmt_len = 16;
                qnan    = 128'h7E00;
            end
            default: ;
        endcase
        upper_mask = '0;
        for (int unsigned j = 0; j < FLEN; j++) begin
            upper_mask[j] = (j >= fmt_len);
        end
        canon_nan    = upper_mask | qnan[FLEN-1:0];
        malformed    = (fmt_len < FLEN) && ((InResult & upper_mask) != upper_mask);
        store_result = malformed ? canon_nan : InResult;
        // enq already excludes Flush, so a flushed bad box leaves BoxErr alone.
        box_err_d    = box_err_q | (enq & malformed);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            box_err_q <= 1'b0;
        end else begin
            box_err_q <= box_err_d;
        end
    end

    assign BoxErr = box_err_q;
`else
    assign store_result = InResult;
    assign BoxErr       = 1'b0;
`endif

endmodule
